// File: rtl/dfr_pkg.sv
// Shared types and constants for the delayed-feedback reservoir run sequencer.
package dfr_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_ADV,
        ST_DONE
    } state_t;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_INIT  = 2'd1;
    localparam logic [1:0] PH_TRAIN = 2'd2;
    localparam logic [1:0] PH_TEST  = 2'd3;

endpackage

// File: rtl/dfr_phase_counter.sv
// Per-phase step/sub-sample/sample counters; cleared on each phase load and
// reporting when a sample completes and when the phase limit is hit.
module dfr_phase_counter
    import dfr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             S_AXI_ACLK,
    input  logic             Local_Reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] step_limit,
    input  logic [CNT_W-1:0] sample_limit,
    input  logic [CNT_W-1:0] steps_per_sample,
    output logic             sample_tick,
    output logic             phase_end
);

    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] sps_eff, step_nxt, sub_nxt, sample_nxt;

    always_comb begin
        // A zero steps-per-sample setting behaves as one step per sample.
        sps_eff      = (steps_per_sample == '0) ? CNT_W'(1) : steps_per_sample;
        step_nxt     = step_cnt_q + 1'b1;
        sub_nxt      = sub_cnt_q + 1'b1;
        sample_tick  = inc && (sub_nxt == sps_eff);
        sample_nxt   = sample_tick ? sample_cnt_q + 1'b1 : sample_cnt_q;
        phase_end    = inc && ((step_nxt == step_limit) || (sample_nxt == sample_limit));
        step_cnt_d   = step_cnt_q;
        sub_cnt_d    = sub_cnt_q;
        sample_cnt_d = sample_cnt_q;
        if (clear) begin
            step_cnt_d   = '0;
            sub_cnt_d    = '0;
            sample_cnt_d = '0;
        end else if (inc) begin
            step_cnt_d   = step_nxt;
            sub_cnt_d    = sample_tick ? '0 : sub_nxt;
            sample_cnt_d = sample_nxt;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            step_cnt_q   <= '0;
            sub_cnt_q    <= '0;
            sample_cnt_q <= '0;
        end else begin
            step_cnt_q   <= step_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

endmodule

// File: rtl/dfr_sequencer.sv
// Run-control sequencer: walks the reservoir through INIT, TRAIN and TEST one
// handshaken step at a time and maintains the global input-sample index.
module dfr_sequencer
    import dfr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             S_AXI_ACLK,
    input  logic             Local_Reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_init_samples,
    input  logic [CNT_W-1:0] num_train_samples,
    input  logic [CNT_W-1:0] num_test_samples,
    input  logic [CNT_W-1:0] num_init_steps,
    input  logic [CNT_W-1:0] num_train_steps,
    input  logic [CNT_W-1:0] num_test_steps,
    input  logic [CNT_W-1:0] num_steps_per_sample,
    output logic             step_req,
    input  logic             step_ack,
    output logic [CNT_W-1:0] sample_idx,
    output logic [1:0]       phase,
    output logic             train_en,
    output logic             test_en,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic             train_en_q, train_en_d, test_en_q, test_en_d;
    logic             busy_q, busy_d, step_req_q, step_req_d;
    logic [CNT_W-1:0] sample_idx_q, sample_idx_d;
    logic [CNT_W-1:0] init_smp_q, init_smp_d, train_smp_q, train_smp_d, test_smp_q, test_smp_d;
    logic [CNT_W-1:0] init_stp_q, init_stp_d, train_stp_q, train_stp_d, test_stp_q, test_stp_d;
    logic [CNT_W-1:0] sps_q, sps_d;
    logic [CNT_W-1:0] step_limit, sample_limit;
    logic             abort_hit, cnt_clear, cnt_inc, sample_tick, phase_end;

    always_comb begin
        abort_hit = abort && (state_q != ST_IDLE);
        cnt_clear = (state_q == ST_LOAD) && !abort_hit;
        cnt_inc   = (state_q == ST_WAIT) && step_ack && !abort_hit;
        case (phase_q)
            PH_TRAIN: begin step_limit = train_stp_q; sample_limit = train_smp_q; end
            PH_TEST:  begin step_limit = test_stp_q;  sample_limit = test_smp_q;  end
            default:  begin step_limit = init_stp_q;  sample_limit = init_smp_q;  end
        endcase
    end

    dfr_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
        .S_AXI_ACLK       (S_AXI_ACLK),
        .Local_Reset      (Local_Reset),
        .clear            (cnt_clear),
        .inc              (cnt_inc),
        .step_limit       (step_limit),
        .sample_limit     (sample_limit),
        .steps_per_sample (sps_q),
        .sample_tick      (sample_tick),
        .phase_end        (phase_end)
    );

    always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
        if (Local_Reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_IDLE;
            train_en_q   <= 1'b0;
            test_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            step_req_q   <= 1'b0;
            sample_idx_q <= '0;
            init_smp_q   <= '0;
            train_smp_q  <= '0;
            test_smp_q   <= '0;
            init_stp_q   <= '0;
            train_stp_q  <= '0;
            test_stp_q   <= '0;
            sps_q        <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            train_en_q   <= train_en_d;
            test_en_q    <= test_en_d;
            busy_q       <= busy_d;
            step_req_q   <= step_req_d;
            sample_idx_q <= sample_idx_d;
            init_smp_q   <= init_smp_d;
            train_smp_q  <= train_smp_d;
            test_smp_q   <= test_smp_d;
            init_stp_q   <= init_stp_d;
            train_stp_q  <= train_stp_d;
            test_stp_q   <= test_stp_d;
            sps_q        <= sps_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_hit) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_LOAD;
                ST_LOAD:  state_d = ((step_limit == '0) || (sample_limit == '0)) ? ST_ADV : ST_ISSUE;
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT:  if (step_ack) state_d = phase_end ? ST_ADV : ST_ISSUE;
                ST_ADV:   state_d = (phase_q == PH_TEST) ? ST_DONE : ST_LOAD;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        phase_d      = phase_q;
        train_en_d   = train_en_q;
        test_en_d    = test_en_q;
        busy_d       = busy_q;
        step_req_d   = step_req_q;
        sample_idx_d = sample_idx_q;
        init_smp_d   = init_smp_q;
        train_smp_d  = train_smp_q;
        test_smp_d   = test_smp_q;
        init_stp_d   = init_stp_q;
        train_stp_d  = train_stp_q;
        test_stp_d   = test_stp_q;
        sps_d        = sps_q;
        done         = (state_q == ST_DONE);
        if (abort_hit) begin
            // Counters and sample_idx freeze; only control outputs fall.
            phase_d    = PH_IDLE;
            train_en_d = 1'b0;
            test_en_d  = 1'b0;
            busy_d     = 1'b0;
            step_req_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    init_smp_d   = num_init_samples;
                    train_smp_d  = num_train_samples;
                    test_smp_d   = num_test_samples;
                    init_stp_d   = num_init_steps;
                    train_stp_d  = num_train_steps;
                    test_stp_d   = num_test_steps;
                    sps_d        = num_steps_per_sample;
                    sample_idx_d = '0;
                    busy_d       = 1'b1;
                    phase_d      = PH_INIT;
                end
                ST_ISSUE: step_req_d = 1'b1;
                ST_WAIT: if (step_ack) begin
                    step_req_d = 1'b0;
                    if (sample_tick) sample_idx_d = sample_idx_q + 1'b1;
                end
                ST_ADV: begin
                    if (phase_q == PH_INIT) begin
                        phase_d    = PH_TRAIN;
                        train_en_d = 1'b1;
                    end else if (phase_q == PH_TRAIN) begin
                        phase_d    = PH_TEST;
                        train_en_d = 1'b0;
                        test_en_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    phase_d    = PH_IDLE;
                    train_en_d = 1'b0;
                    test_en_d  = 1'b0;
                    busy_d     = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign step_req   = step_req_q;
    assign sample_idx = sample_idx_q;
    assign phase      = phase_q;
    assign train_en   = train_en_q;
    assign test_en    = test_en_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dfr_sequencer.sv
// Self-checking bench for dfr_sequencer: fixed run table, abort/reset
// sequences and randomized runs against a step-list reference model.
module tb_dfr_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, abort, step_ack;
    logic [W-1:0] n_is, n_ts, n_xs, n_ist, n_tst, n_xst, n_sps;
    logic         step_req, train_en, test_en, busy, done;
    logic [W-1:0] sample_idx;
    logic [1:0]   phase;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int smp_i, smp_tr, smp_te, stp_i, stp_tr, stp_te, sps;
    } cfg_t;

    typedef struct {
        cfg_t c;
        bit   disturb;
        int   exp_req, exp_idx, exp_done;
    } vec_t;

    typedef struct {
        int ph;
        int idx;
    } step_t;

    step_t exp_q[$];
    int    exp_n, exp_idx;
    int    phase_log[$];

    dfr_sequencer #(.CNT_W(W)) dut (
        .S_AXI_ACLK           (clk),
        .Local_Reset          (rst),
        .start                (start),
        .abort                (abort),
        .num_init_samples     (n_is),
        .num_train_samples    (n_ts),
        .num_test_samples     (n_xs),
        .num_init_steps       (n_ist),
        .num_train_steps      (n_tst),
        .num_test_steps       (n_xst),
        .num_steps_per_sample (n_sps),
        .step_req             (step_req),
        .step_ack             (step_ack),
        .sample_idx           (sample_idx),
        .phase                (phase),
        .train_en             (train_en),
        .test_en              (test_en),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: each phase runs min(step limit, sample limit * sps) steps;
    // the sample index during step k of a phase is base + k / sps.
    function automatic void build_expect(input cfg_t c);
        int    smp[3];
        int    stp[3];
        int    s, n, base;
        step_t e;
        smp = '{c.smp_i, c.smp_tr, c.smp_te};
        stp = '{c.stp_i, c.stp_tr, c.stp_te};
        exp_q.delete();
        base  = 0;
        exp_n = 0;
        s = (c.sps == 0) ? 1 : c.sps;
        for (int p = 0; p < 3; p++) begin
            n = (stp[p] < smp[p] * s) ? stp[p] : smp[p] * s;
            for (int k = 0; k < n; k++) begin
                e.ph  = p + 1;
                e.idx = base + k / s;
                exp_q.push_back(e);
            end
            base  += n / s;
            exp_n += n;
        end
        exp_idx = base;
    endfunction

    task automatic apply(input cfg_t c);
        n_is  = W'(c.smp_i);
        n_ts  = W'(c.smp_tr);
        n_xs  = W'(c.smp_te);
        n_ist = W'(c.stp_i);
        n_tst = W'(c.stp_tr);
        n_xst = W'(c.stp_te);
        n_sps = W'(c.sps);
    endtask

    // One full run: pulse start, answer each step_req after lat cycles
    // (lat < 0 picks a random latency 0..3 per step), stop one cycle after done.
    task automatic run(input cfg_t c, input int lat, input bit disturb,
                       output int n_req, output int done_cyc, output int latsum, output int done_cnt);
        int    cyc, cd;
        bit    in_req;
        step_t e;
        build_expect(c);
        phase_log.delete();
        @(negedge clk);
        apply(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; n_req = 0; done_cyc = -1; latsum = 0; done_cnt = 0; in_req = 0; cd = 0;
        while (cyc < 4000) begin
            phase_log.push_back(int'(phase));
            if (cyc == 1) begin
                chk("busy_rise", busy, 1);
                chk("phase_init", phase, 1);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            start = disturb && (cyc == 5);
            if (disturb && cyc == 5) begin
                n_tst = 1;
                n_ts  = 1;
            end
            if (step_req) begin
                if (!in_req) begin
                    in_req = 1;
                    n_req++;
                    cd = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
                    latsum += cd;
                    if (exp_q.size() == 0) begin
                        chk("extra_step_req", n_req, exp_n);
                    end else begin
                        e = exp_q.pop_front();
                        chk("step_phase", phase, e.ph);
                        chk("step_idx", sample_idx, e.idx);
                        chk("step_train_en", train_en, e.ph == 2);
                        chk("step_test_en", test_en, e.ph == 3);
                    end
                end
                step_ack = (cd == 0);
                if (cd > 0) cd--;
            end else begin
                in_req   = 0;
                step_ack = 1'b0;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
            @(negedge clk);
            cyc++;
        end
        step_ack = 1'b0;
        start    = 1'b0;
        chk("done_seen", done_cyc >= 0, 1);
    endtask

    task automatic post_checks(input int n_req, input int done_cyc, input int done_cnt,
                               input int e_req, input int e_idx, input int e_done);
        chk("req_count", n_req, e_req);
        chk("final_idx", sample_idx, e_idx);
        chk("done_cycle", done_cyc, e_done);
        chk("done_pulses", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("phase_after", phase, 0);
        chk("model_left", exp_q.size(), 0);
    endtask

    // Drive lat-0 acks until the n-th step_req is seen (left high, unacked).
    task automatic step_until(input int n);
        int  k, seen;
        bit  in_req;
        k = 0; seen = 0; in_req = 0;
        while (k < 400) begin
            if (step_req && !in_req) begin
                in_req = 1;
                seen++;
                if (seen == n) break;
            end
            if (!step_req) in_req = 0;
            step_ack = step_req;
            @(negedge clk);
            k++;
        end
        step_ack = 1'b0;
        chk("reach_step", seen, n);
    endtask

    initial begin
        vec_t tbl[7];
        int   zp[8];
        cfg_t c;
        int   n_req, done_cyc, latsum, done_cnt, seen_done;

        tbl[0] = '{'{1, 2, 1, 3, 6, 3, 3}, 1'b0, 12, 4, 43};
        tbl[1] = '{'{0, 10, 0, 0, 4, 0, 2}, 1'b0, 4, 2, 19};
        tbl[2] = '{'{0, 0, 0, 0, 0, 0, 0}, 1'b0, 0, 0, 7};
        tbl[3] = '{'{2, 0, 0, 5, 0, 0, 0}, 1'b0, 2, 2, 13};
        tbl[4] = '{'{0, 5, 4, 4, 3, 0, 1}, 1'b0, 3, 3, 16};
        tbl[5] = '{'{4, 0, 1, 5, 0, 1, 2}, 1'b0, 6, 2, 25};
        tbl[6] = '{'{1, 2, 1, 3, 6, 3, 3}, 1'b1, 12, 4, 43};
        zp = '{1, 1, 2, 2, 3, 3, 3, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; step_ack = 1'b0;
        apply(tbl[2].c);
        repeat (2) @(negedge clk);
        chk("rst_step_req", step_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_phase", phase, 0);
        chk("rst_sample_idx", sample_idx, 0);
        chk("rst_train_en", train_en, 0);
        chk("rst_test_en", test_en, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].c, 1, tbl[i].disturb, n_req, done_cyc, latsum, done_cnt);
            post_checks(n_req, done_cyc, done_cnt, tbl[i].exp_req, tbl[i].exp_idx, tbl[i].exp_done);
            if (i == 2) begin
                for (int j = 0; j < 8; j++)
                    chk("zero_phase_seq", (phase_log.size() > j) ? phase_log[j] : -1, zp[j]);
            end
        end

        // Abort during WAIT of the third TRAIN step, with a simultaneous ack.
        c = '{0, 6, 0, 0, 6, 0, 1};
        @(negedge clk);
        apply(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step_until(3);
        chk("pre_abort_idx", sample_idx, 2);
        abort    = 1'b1;
        step_ack = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        step_ack = 1'b0;
        chk("abort_step_req", step_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_train_en", train_en, 0);
        chk("abort_idx_frozen", sample_idx, 2);
        seen_done = 0;
        for (int j = 0; j < 10; j++) begin
            if (done || step_req) seen_done++;
            @(negedge clk);
        end
        chk("abort_quiet", seen_done, 0);
        run(tbl[4].c, 0, 1'b0, n_req, done_cyc, latsum, done_cnt);
        post_checks(n_req, done_cyc, done_cnt, exp_n, exp_idx, 7 + 2 * exp_n + latsum);

        // Asynchronous reset in mid-WAIT, then a late ack that must be ignored.
        c = '{5, 0, 0, 5, 0, 0, 1};
        @(negedge clk);
        apply(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step_until(3);
        chk("pre_rst_idx", sample_idx, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_step_req", step_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_phase", phase, 0);
        chk("arst_idx", sample_idx, 0);
        @(negedge clk);
        rst      = 1'b0;
        step_ack = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("late_ack_req", step_req, 0);
            chk("late_ack_busy", busy, 0);
        end
        step_ack = 1'b0;

        for (int r = 0; r < 20; r++) begin
            c.smp_i  = int'($urandom_range(0, 4));
            c.smp_tr = int'($urandom_range(0, 4));
            c.smp_te = int'($urandom_range(0, 4));
            c.stp_i  = int'($urandom_range(0, 5));
            c.stp_tr = int'($urandom_range(0, 5));
            c.stp_te = int'($urandom_range(0, 5));
            c.sps    = int'($urandom_range(0, 3));
            run(c, -1, 1'b0, n_req, done_cyc, latsum, done_cnt);
            post_checks(n_req, done_cyc, done_cnt, exp_n, exp_idx, 7 + 2 * exp_n + latsum);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
